// File: rtl/cmac_tx_axis_arbiter.sv
// ---------------------------------------------------------------------------
// cmac_tx_axis_arbiter
// Packet-granular round-robin arbiter that shares the single 512-bit CMAC TX
// AXI4-Stream between NUM_SRC requesters (txusrclk2 domain). Packets are never
// interleaved; a packet that runs past MAX_BEATS is cut with tlast+tuser and
// its remainder is drained from the source so a stuck source cannot hold the
// MAC.
//
// Ports
//   clk, reset        : txusrclk2 clock, async active-high reset (usr_tx_reset)
//   tx_enable         : allows the start of new packets (never aborts one)
//   s_t*              : NUM_SRC slave streams, source i at [i*W +: W]
//   m_t*              : master stream to cmac_usplus_0 tx_axis
//   grant             : one-hot owner of the current packet, 0 when idle
//   busy              : high while a packet is owned (XFER or DRAIN)
//   trunc_pulse       : one-cycle pulse after each forced truncation
//
// Optional feature (macro CMAC_TX_ARB_STATS_EN):
//   pkt_cnt   : per-source packet counters, source i at [i*32 +: 32], wrap
//   trunc_cnt : saturating count of forced truncations
// ---------------------------------------------------------------------------
module cmac_tx_axis_arbiter #(
   parameter int unsigned NUM_SRC   = 2,
   parameter int unsigned DATA_W    = 512,
   parameter int unsigned KEEP_W    = 64,
   parameter int unsigned MAX_BEATS = 256
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      tx_enable,
   input  logic [NUM_SRC-1:0]        s_tvalid,
   output logic [NUM_SRC-1:0]        s_tready,
   input  logic [NUM_SRC*DATA_W-1:0] s_tdata,
   input  logic [NUM_SRC*KEEP_W-1:0] s_tkeep,
   input  logic [NUM_SRC-1:0]        s_tlast,
   input  logic [NUM_SRC-1:0]        s_tuser,
   output logic                      m_tvalid,
   input  logic                      m_tready,
   output logic [DATA_W-1:0]         m_tdata,
   output logic [KEEP_W-1:0]         m_tkeep,
   output logic                      m_tlast,
   output logic                      m_tuser,
   output logic [NUM_SRC-1:0]        grant,
   output logic                      busy,
`ifdef CMAC_TX_ARB_STATS_EN
   output logic [NUM_SRC*32-1:0]     pkt_cnt,
   output logic [15:0]               trunc_cnt,
`endif
   output logic                      trunc_pulse
);

   localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_BEATS) + 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BEATS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_XFER  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   gnt_idx;
   logic [IDX_W-1:0]   last_grant;
   logic [CNT_W-1:0]   beat_cnt;

   logic [IDX_W-1:0]   next_idx;
   logic               next_found;
   int unsigned        cand;

   logic               sel_valid;
   logic               sel_last;
   logic               sel_user;
   logic [DATA_W-1:0]  sel_data;
   logic [KEEP_W-1:0]  sel_keep;

   logic               beat;
   logic               at_limit;
   logic               trunc_beat;
   logic               drain_done;

   // Round-robin pick: first requester scanning upward from last_grant+1.
   always_comb begin
      next_found = 1'b0;
      next_idx   = last_grant;
      cand       = 0;
      for (int unsigned k = 1; k <= NUM_SRC; k++) begin
         cand = (32'(last_grant) + k) % NUM_SRC;
         if (!next_found && s_tvalid[IDX_W'(cand)]) begin
            next_found = 1'b1;
            next_idx   = IDX_W'(cand);
         end
      end
   end

   // Mux of the currently granted source.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_user  = 1'b0;
      sel_data  = '0;
      sel_keep  = '0;
      for (int i = 0; i < int'(NUM_SRC); i++) begin
         if (gnt_idx == IDX_W'(i)) begin
            sel_valid = s_tvalid[i];
            sel_last  = s_tlast[i];
            sel_user  = s_tuser[i];
            sel_data  = s_tdata[i*DATA_W +: DATA_W];
            sel_keep  = s_tkeep[i*KEEP_W +: KEEP_W];
         end
      end
   end

   assign beat       = (state == ST_XFER) && sel_valid && m_tready;
   assign at_limit   = (beat_cnt == LAST_BEAT);
   assign trunc_beat = beat && at_limit && !sel_last;
   // s_tready of the owner is forced high while draining.
   assign drain_done = (state == ST_DRAIN) && sel_valid && sel_last;

   // Stream outputs: pass-through in XFER, quiet otherwise. The beat that
   // reaches the limit is always terminated; it is flagged bad unless the
   // source happened to end the packet there.
   always_comb begin
      s_tready = '0;
      m_tvalid = 1'b0;
      m_tdata  = '0;
      m_tkeep  = '0;
      m_tlast  = 1'b0;
      m_tuser  = 1'b0;
      case (state)
         ST_XFER: begin
            m_tvalid = sel_valid;
            m_tdata  = sel_data;
            m_tkeep  = sel_keep;
            m_tlast  = sel_last | at_limit;
            m_tuser  = sel_user | (at_limit & ~sel_last);
            s_tready = grant & {NUM_SRC{m_tready}};
         end
         ST_DRAIN: begin
            s_tready = grant;
         end
         default: ;
      endcase
   end

   // Packet ownership FSM with registered grant/busy/trunc_pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         grant       <= '0;
         gnt_idx     <= '0;
         last_grant  <= IDX_W'(NUM_SRC - 1);
         beat_cnt    <= '0;
         busy        <= 1'b0;
         trunc_pulse <= 1'b0;
      end else begin
         trunc_pulse <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (tx_enable && next_found) begin
                  state    <= ST_XFER;
                  gnt_idx  <= next_idx;
                  grant    <= NUM_SRC'(1) << next_idx;
                  beat_cnt <= '0;
                  busy     <= 1'b1;
               end
            end
            ST_XFER: begin
               if (beat) begin
                  if (sel_last) begin
                     state      <= ST_IDLE;
                     last_grant <= gnt_idx;
                     grant      <= '0;
                     beat_cnt   <= '0;
                     busy       <= 1'b0;
                  end else if (at_limit) begin
                     state       <= ST_DRAIN;
                     beat_cnt    <= '0;
                     trunc_pulse <= 1'b1;
                  end else begin
                     beat_cnt <= beat_cnt + CNT_W'(1);
                  end
               end
            end
            ST_DRAIN: begin
               if (drain_done) begin
                  state      <= ST_IDLE;
                  last_grant <= gnt_idx;
                  grant      <= '0;
                  busy       <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               grant <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef CMAC_TX_ARB_STATS_EN
   // Per-source packet counters (natural or forced tlast) and truncation count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pkt_cnt   <= '0;
         trunc_cnt <= '0;
      end else begin
         if (beat && m_tlast) begin
            for (int i = 0; i < int'(NUM_SRC); i++) begin
               if (gnt_idx == IDX_W'(i)) begin
                  pkt_cnt[i*32 +: 32] <= pkt_cnt[i*32 +: 32] + 32'd1;
               end
            end
         end
         if (trunc_beat && (trunc_cnt != 16'hFFFF)) begin
            trunc_cnt <= trunc_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_cmac_tx_axis_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cmac_tx_axis_arbiter
// Directed, table-driven bench. Each vector is one clock cycle of stimulus
// plus the outputs expected in that cycle. Two arbiters share the stimulus:
// dut (MAX_BEATS=256) for normal traffic and dut_t (MAX_BEATS=8) for the
// truncation case.
// ---------------------------------------------------------------------------
module tb_cmac_tx_axis_arbiter;

   localparam int unsigned NS = 2;
   localparam int unsigned DW = 512;
   localparam int unsigned KW = 64;

   logic            clk;
   logic            reset;
   logic            tx_enable;
   logic [NS-1:0]   s_tvalid;
   logic [NS*DW-1:0] s_tdata;
   logic [NS*KW-1:0] s_tkeep;
   logic [NS-1:0]   s_tlast;
   logic [NS-1:0]   s_tuser;
   logic            m_tready;

   logic [NS-1:0]   s_tready_a, s_tready_b;
   logic            m_tvalid_a, m_tvalid_b;
   logic [DW-1:0]   m_tdata_a, m_tdata_b;
   logic [KW-1:0]   m_tkeep_a, m_tkeep_b;
   logic            m_tlast_a, m_tlast_b;
   logic            m_tuser_a, m_tuser_b;
   logic [NS-1:0]   grant_a, grant_b;
   logic            busy_a, busy_b;
   logic            trunc_a, trunc_b;
`ifdef CMAC_TX_ARB_STATS_EN
   logic [NS*32-1:0] pkt_cnt_a, pkt_cnt_b;
   logic [15:0]      trunc_cnt_a, trunc_cnt_b;
`endif

   int n_chk;
   int n_fail;

   cmac_tx_axis_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .KEEP_W(KW), .MAX_BEATS(256)) dut (
      .clk(clk), .reset(reset), .tx_enable(tx_enable),
      .s_tvalid(s_tvalid), .s_tready(s_tready_a), .s_tdata(s_tdata),
      .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tuser(s_tuser),
      .m_tvalid(m_tvalid_a), .m_tready(m_tready), .m_tdata(m_tdata_a),
      .m_tkeep(m_tkeep_a), .m_tlast(m_tlast_a), .m_tuser(m_tuser_a),
      .grant(grant_a), .busy(busy_a),
`ifdef CMAC_TX_ARB_STATS_EN
      .pkt_cnt(pkt_cnt_a), .trunc_cnt(trunc_cnt_a),
`endif
      .trunc_pulse(trunc_a)
   );

   cmac_tx_axis_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .KEEP_W(KW), .MAX_BEATS(8)) dut_t (
      .clk(clk), .reset(reset), .tx_enable(tx_enable),
      .s_tvalid(s_tvalid), .s_tready(s_tready_b), .s_tdata(s_tdata),
      .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tuser(s_tuser),
      .m_tvalid(m_tvalid_b), .m_tready(m_tready), .m_tdata(m_tdata_b),
      .m_tkeep(m_tkeep_b), .m_tlast(m_tlast_b), .m_tuser(m_tuser_b),
      .grant(grant_b), .busy(busy_b),
`ifdef CMAC_TX_ARB_STATS_EN
      .pkt_cnt(pkt_cnt_b), .trunc_cnt(trunc_cnt_b),
`endif
      .trunc_pulse(trunc_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       t;      // check dut_t instead of dut
      logic       en;
      logic [1:0] vld;
      logic [1:0] lst;
      logic [1:0] usr;
      logic [7:0] tg0;
      logic [7:0] tg1;
      logic       rdy;
      logic [1:0] e_gnt;
      logic [1:0] e_srdy;
      logic       e_vld;
      logic       e_lst;
      logic       e_usr;
      logic [7:0] e_tag;
      logic       e_busy;
      logic       e_trc;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mkv(input logic t, input logic en, input logic [1:0] vld,
                                input logic [1:0] lst, input logic [1:0] usr,
                                input logic [7:0] tg0, input logic [7:0] tg1, input logic rdy,
                                input logic [1:0] eg, input logic [1:0] es, input logic ev,
                                input logic el, input logic eu, input logic [7:0] et,
                                input logic eb, input logic etr);
      vec_t x;
      x.t = t; x.en = en; x.vld = vld; x.lst = lst; x.usr = usr;
      x.tg0 = tg0; x.tg1 = tg1; x.rdy = rdy;
      x.e_gnt = eg; x.e_srdy = es; x.e_vld = ev; x.e_lst = el; x.e_usr = eu;
      x.e_tag = et; x.e_busy = eb; x.e_trc = etr;
      return x;
   endfunction

   // Cycle in which the arbiter owns nothing: every output quiet.
   function automatic vec_t idle_v(input logic t, input logic en, input logic [1:0] vld,
                                   input logic [1:0] lst, input logic [7:0] tg0,
                                   input logic [7:0] tg1);
      return mkv(t, en, vld, lst, 2'b00, tg0, tg1, 1'b1,
                 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
   endfunction

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic en, input logic [1:0] vld, input logic [1:0] lst,
                        input logic [1:0] usr, input logic [7:0] tg0, input logic [7:0] tg1,
                        input logic rdy);
      tx_enable = en;
      s_tvalid  = vld;
      s_tlast   = lst;
      s_tuser   = usr;
      s_tdata   = {{64{tg1}}, {64{tg0}}};
      s_tkeep   = {{8{tg1}}, {8{tg0}}};
      m_tready  = rdy;
   endtask

   task automatic run_vecs(input string scen);
      vec_t x;
      logic [1:0] g, sr;
      logic mv, ml, mu, bz, tp;
      logic [DW-1:0] md;
      logic [KW-1:0] mk;
      for (int i = 0; i < vq.size(); i++) begin
         x = vq[i];
         @(posedge clk);
         #1;
         drive(x.en, x.vld, x.lst, x.usr, x.tg0, x.tg1, x.rdy);
         @(negedge clk);
         if (x.t) begin
            g = grant_b; sr = s_tready_b; mv = m_tvalid_b; ml = m_tlast_b; mu = m_tuser_b;
            bz = busy_b; tp = trunc_b; md = m_tdata_b; mk = m_tkeep_b;
         end else begin
            g = grant_a; sr = s_tready_a; mv = m_tvalid_a; ml = m_tlast_a; mu = m_tuser_a;
            bz = busy_a; tp = trunc_a; md = m_tdata_a; mk = m_tkeep_a;
         end
         chk($sformatf("%s[%0d] grant", scen, i), DW'(g), DW'(x.e_gnt));
         chk($sformatf("%s[%0d] s_tready", scen, i), DW'(sr), DW'(x.e_srdy));
         chk($sformatf("%s[%0d] m_tvalid", scen, i), DW'(mv), DW'(x.e_vld));
         chk($sformatf("%s[%0d] m_tlast", scen, i), DW'(ml), DW'(x.e_lst));
         chk($sformatf("%s[%0d] m_tuser", scen, i), DW'(mu), DW'(x.e_usr));
         chk($sformatf("%s[%0d] busy", scen, i), DW'(bz), DW'(x.e_busy));
         chk($sformatf("%s[%0d] trunc_pulse", scen, i), DW'(tp), DW'(x.e_trc));
         chk($sformatf("%s[%0d] m_tdata", scen, i), md,
             x.e_vld ? {64{x.e_tag}} : DW'(0));
         chk($sformatf("%s[%0d] m_tkeep", scen, i), DW'(mk),
             x.e_vld ? DW'({8{x.e_tag}}) : DW'(0));
      end
      vq.delete();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      drive(1'b0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, n1, n;
      logic o;
      logic [7:0] t0, t1;
      logic l0, l1, r;

      n_chk  = 0;
      n_fail = 0;
      reset  = 1'b1;
      drive(1'b0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      // Reset state of both instances.
      chk("rst grant", DW'(grant_a), DW'(0));
      chk("rst busy", DW'(busy_a), DW'(0));
      chk("rst m_tvalid", DW'(m_tvalid_a), DW'(0));
      chk("rst s_tready", DW'(s_tready_a), DW'(0));
      chk("rst trunc", DW'(trunc_a), DW'(0));
      chk("rst grant_t", DW'(grant_b), DW'(0));
      chk("rst busy_t", DW'(busy_b), DW'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Single 9-beat packet from src0.
      vq.push_back(idle_v(1'b0, 1'b1, 2'b01, 2'b00, 8'd1, 8'd0));
      for (int b = 1; b <= 9; b++)
         vq.push_back(mkv(1'b0, 1'b1, 2'b01, {1'b0, b == 9}, 2'b00, 8'(b), 8'd0, 1'b1,
                          2'b01, 2'b01, 1'b1, b == 9, 1'b0, 8'(b), 1'b1, 1'b0));
      vq.push_back(idle_v(1'b0, 1'b1, 2'b00, 2'b00, 8'd0, 8'd0));
      run_vecs("single");

      // Both sources request 3-beat packets continuously: owners alternate 0,1,...
      do_reset();
      n0 = 0;
      n1 = 0;
      for (int p = 0; p < 6; p++) begin
         o  = p[0];
         t0 = 8'h10 + 8'(n0);
         t1 = 8'h80 + 8'(n1);
         l0 = (n0 % 3) == 2;
         l1 = (n1 % 3) == 2;
         vq.push_back(idle_v(1'b0, 1'b1, 2'b11, {l1, l0}, t0, t1));
         for (int b = 0; b < 3; b++) begin
            t0 = 8'h10 + 8'(n0);
            t1 = 8'h80 + 8'(n1);
            l0 = (n0 % 3) == 2;
            l1 = (n1 % 3) == 2;
            vq.push_back(mkv(1'b0, 1'b1, 2'b11, {l1, l0}, 2'b00, t0, t1, 1'b1,
                             o ? 2'b10 : 2'b01, o ? 2'b10 : 2'b01, 1'b1, b == 2, 1'b0,
                             o ? t1 : t0, 1'b1, 1'b0));
            if (o) n1++; else n0++;
         end
      end
      vq.push_back(idle_v(1'b0, 1'b1, 2'b00, 2'b00, 8'd0, 8'd0));
      run_vecs("rr");

      // m_tready toggling during a 5-beat src0 packet; src1 waits.
      do_reset();
      vq.push_back(idle_v(1'b0, 1'b1, 2'b11, 2'b00, 8'h20, 8'h80));
      n = 0;
      for (int c = 0; c < 9; c++) begin
         r  = (c % 2) == 0;
         t0 = 8'h20 + 8'(n);
         vq.push_back(mkv(1'b0, 1'b1, 2'b11, {1'b0, n == 4}, {1'b0, n == 4}, t0, 8'h80, r,
                          2'b01, {1'b0, r}, 1'b1, n == 4, n == 4, t0, 1'b1, 1'b0));
         if (r) n++;
      end
      vq.push_back(idle_v(1'b0, 1'b1, 2'b10, 2'b00, 8'h00, 8'h80));
      vq.push_back(mkv(1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 8'h00, 8'h80, 1'b0,
                       2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0));
      run_vecs("stall");

      // MAX_BEATS=8 instance: 12-beat src1 packet is cut at beat 8, rest drained.
      do_reset();
      vq.push_back(idle_v(1'b1, 1'b1, 2'b10, 2'b00, 8'd0, 8'd1));
      for (int b = 1; b <= 8; b++)
         vq.push_back(mkv(1'b1, 1'b1, 2'b10, 2'b00, 2'b00, 8'd0, 8'(b), 1'b1,
                          2'b10, 2'b10, 1'b1, b == 8, b == 8, 8'(b), 1'b1, 1'b0));
      for (int b = 9; b <= 12; b++)
         vq.push_back(mkv(1'b1, 1'b1, 2'b10, {b == 12, 1'b0}, 2'b00, 8'd0, 8'(b), 1'b1,
                          2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, b == 9));
      vq.push_back(idle_v(1'b1, 1'b1, 2'b00, 2'b00, 8'd0, 8'd0));
      run_vecs("trunc");

      // tx_enable gates only packet starts.
      do_reset();
      for (int c = 0; c < 3; c++)
         vq.push_back(idle_v(1'b0, 1'b0, 2'b01, 2'b00, 8'd1, 8'd0));
      vq.push_back(idle_v(1'b0, 1'b1, 2'b01, 2'b00, 8'd1, 8'd0));
      for (int b = 1; b <= 3; b++)
         vq.push_back(mkv(1'b0, 1'b0, 2'b01, {1'b0, b == 3}, 2'b00, 8'(b), 8'd0, 1'b1,
                          2'b01, 2'b01, 1'b1, b == 3, 1'b0, 8'(b), 1'b1, 1'b0));
      vq.push_back(idle_v(1'b0, 1'b0, 2'b01, 2'b01, 8'd4, 8'd0));
      vq.push_back(idle_v(1'b0, 1'b0, 2'b01, 2'b01, 8'd4, 8'd0));
      vq.push_back(idle_v(1'b0, 1'b1, 2'b01, 2'b01, 8'd4, 8'd0));
      vq.push_back(mkv(1'b0, 1'b1, 2'b01, 2'b01, 2'b00, 8'd4, 8'd0, 1'b1,
                       2'b01, 2'b01, 1'b1, 1'b1, 1'b0, 8'd4, 1'b1, 1'b0));
      vq.push_back(idle_v(1'b0, 1'b1, 2'b00, 2'b00, 8'd0, 8'd0));
      run_vecs("txen");

      // Reset asserted on beat 3 of a 6-beat src0 packet.
      do_reset();
      vq.push_back(idle_v(1'b0, 1'b1, 2'b01, 2'b00, 8'd1, 8'd0));
      for (int b = 1; b <= 2; b++)
         vq.push_back(mkv(1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 8'(b), 8'd0, 1'b1,
                          2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 8'(b), 1'b1, 1'b0));
      run_vecs("midrst");
      @(posedge clk);
      #1;
      drive(1'b1, 2'b01, 2'b00, 2'b00, 8'd3, 8'd0, 1'b1);
      #1;
      chk("midrst beat3 m_tvalid", DW'(m_tvalid_a), DW'(1));
      reset = 1'b1;
      #1;
      chk("midrst async grant", DW'(grant_a), DW'(0));
      chk("midrst async m_tvalid", DW'(m_tvalid_a), DW'(0));
      chk("midrst async s_tready", DW'(s_tready_a), DW'(0));
      chk("midrst async busy", DW'(busy_a), DW'(0));
      chk("midrst async m_tdata", m_tdata_a, DW'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(1'b1, 2'b11, 2'b00, 2'b00, 8'd1, 8'h81, 1'b1);
      @(negedge clk);
      chk("midrst arb grant", DW'(grant_a), DW'(0));
      chk("midrst arb m_tlast", DW'(m_tlast_a), DW'(0));
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("midrst regrant grant", DW'(grant_a), DW'(1));
      chk("midrst regrant m_tdata", m_tdata_a, {64{8'd1}});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
